ludh_inst_sequencer: RTL and testbench
======================================

Name: ludh_inst_sequencer

Overview:
- Parametrised instruction sequencer that drives the LUD hardware control word (ctrl_signal) from an internal instruction memory.
- The host loads the memory through a 32-bit part-addressed port; NUM_PARTS is derived from CTRL_WIDTH.
- Adds run-to-length, single-step and loop modes, a locked-based pause, an issue counter and a ctrl_valid strobe.
- Sits between the ZYNQ AXI-BRAM glue and LUDHardware, replacing the fixed tester.

Parameters:
- ADDR_WIDTH, 12: instruction memory address width; DEPTH = 2**ADDR_WIDTH.
- CTRL_WIDTH, 72: control word width, 1..256.
- NUM_PARTS, (CTRL_WIDTH+31)/32: number of 32-bit host parts per word (derived localparam).
- PART_SEL_WIDTH, 3: width of the host part select; must satisfy 2**PART_SEL_WIDTH >= NUM_PARTS.

Ports:
- CLK_100  in  1  sole clock; all logic rises on it.
- RST_IN  in  1  asynchronous, active-high reset.
- locked  in  1  clock-good / run enable; low pauses issue.
- START  in  1  level; run request.
- mode  in  2  00 run-to-length, 01 single-step, 10 loop, 11 treated as 00.
- prog_len  in  ADDR_WIDTH+1  instruction count, 0..DEPTH; sampled at start.
- loop_count  in  16  repetitions in loop mode; 0 treated as 1.
- step  in  1  single-step advance pulse.
- host_addr  in  ADDR_WIDTH  instruction index.
- host_part  in  PART_SEL_WIDTH  32-bit slice select.
- host_din  in  32  write data.
- host_en  in  1  host access enable.
- host_we  in  1  host write.
- host_dout  out  32  read data, 1-cycle latency.
- ctrl_signal  out  CTRL_WIDTH  issued control word.
- ctrl_valid  out  1  high for one cycle per issued word.
- COMPLETED  out  1  run finished.
- issued_count  out  32  words issued this run.
- debug_state  out  2  0 IDLE, 1 RUN, 2 STEP_WAIT, 3 DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, PC 0. Reset mid-run aborts immediately; memory contents are unspecified after reset.

Host port:
- Write with host_en & host_we: updates bits [32*part +: 32] of word host_addr, masked to CTRL_WIDTH.
- Part selects >= NUM_PARTS are ignored on write and read back as 0.
- Read: host_dout is registered one cycle after host_en; the top part is zero-extended.
- Host writes are ignored in RUN and STEP_WAIT. Reads are always allowed.
- Same-cycle host read and sequencer fetch are both served; the memory is dual-port.

State machine:
- IDLE: on START=1, latch prog_len, mode and loop_count, and clear issued_count.
  - prog_len=0 goes straight to DONE.
  - Otherwise mode 01 goes to STEP_WAIT; all other modes go to RUN.
- RUN: fetch PC at cycle t; word appears on ctrl_signal with ctrl_valid=1 at t+1.
  - One word per cycle, no bubbles.
  - First ctrl_valid comes 2 cycles after the START sample. N words occupy N consecutive cycles.
  - After the last word (PC = prog_len-1), loop mode with repetitions remaining wraps PC to 0 with no bubble. Otherwise go to DONE.
  - Total issued words in loop mode = prog_len × max(loop_count,1).
- STEP_WAIT: each cycle with step=1 issues exactly one word. The word appears 2 cycles after the step pulse, and further step pulses are ignored until it issues. After the last word go to DONE.
- DONE: COMPLETED=1 and held. When START=0, return to IDLE and drop COMPLETED the same cycle.
- START falling during RUN or STEP_WAIT is ignored; the run continues to completion.

Outputs and pause:
- ctrl_signal is 0 whenever ctrl_valid=0.
- locked=0 in RUN or STEP_WAIT: PC and counters hold, ctrl_valid=0, ctrl_signal=0.
  - A word already fetched is held in a one-entry skid register and issued on the first cycle locked returns high.
  - No word is lost or duplicated.
- issued_count increments on each ctrl_valid and saturates at 2**32-1.
- A prog_len above DEPTH is clamped to DEPTH.

Decomposition:
- Shared package ludh_pkg holds:
  - state encodings IDLE, RUN, STEP_WAIT, DONE;
  - mode encodings;
  - the derived NUM_PARTS function.
- One sub-module, ludh_inst_mem: true dual-port memory with host part-write and a 1-cycle sequencer read port, inferred as BRAM.

Test Plan:
- Host load/readback: write words 0..3 with 3 parts each (CTRL_WIDTH=72), e.g. part2=0xFFFFFFAB. Read part2 → 0x000000AB; read part3 → 0.
- Run-to-length: prog_len=4, mode=00, START held. ctrl_valid high on cycles 2..5 after the START sample, words 0..3 in order. COMPLETED rises on cycle 6; issued_count=4. Dropping START gives IDLE next cycle.
- Loop: prog_len=3, loop_count=2 → 6 consecutive valids in order 0,1,2,0,1,2 with no gap; issued_count=6. Repeat with loop_count=0 → 3 valids.
- Single-step: prog_len=2, mode=01. Pulse step three times, 5 cycles apart → exactly 2 valids, each 2 cycles after its pulse. The third pulse produces nothing, and DONE is reached.
- Pause: drop locked for 4 cycles mid-run at word 5 of 10 → no valid for those cycles. Words resume at 5 with none skipped or repeated; total 10.
- Edge cases:
  - prog_len=0 → COMPLETED one cycle after START, zero valids.
  - Host write during RUN is ignored (readback shows the old value).
  - RST_IN pulsed mid-run → all outputs 0 asynchronously, and the next run restarts at word 0.

Source files
------------

// File: rtl/ludh_pkg.sv
// Shared encodings and helpers for the LUD instruction sequencer.
package ludh_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_STEP = 2'b01,
    MODE_LOOP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Number of 32-bit host parts needed to cover one control word.
  function automatic int num_parts(input int ctrl_width);
    return (ctrl_width + 31) / 32;
  endfunction

endpackage

// File: rtl/ludh_inst_mem.sv
// Instruction store: host port (32-bit part write/read) plus sequencer full-word read port.
// Both reads return data 1 cycle after enable; no backpressure, every access is served.
module ludh_inst_mem
  import ludh_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int CTRL_WIDTH     = 72,
  parameter int PART_SEL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_en,
  input  logic                      host_we,
  input  logic [ADDR_WIDTH-1:0]     host_addr,
  input  logic [PART_SEL_WIDTH-1:0] host_part,
  input  logic [31:0]               host_din,
  output logic [31:0]               host_dout,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [CTRL_WIDTH-1:0]     rd_dat
);

  localparam int NUM_PARTS = num_parts(CTRL_WIDTH);
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int LAST_W    = CTRL_WIDTH - 32*(NUM_PARTS-1);

  logic [31:0]               part_dat [NUM_PARTS];
  logic [PART_SEL_WIDTH-1:0] part_q;
  logic                      rd_seen_q;

  // One column per 32-bit part so each maps to its own dual-port BRAM.
  for (genvar g = 0; g < NUM_PARTS; g++) begin : g_part
    localparam int PW = (g == NUM_PARTS-1) ? LAST_W : 32;
    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] host_q;
    logic [PW-1:0] seq_q;

    always_ff @(posedge clk) begin
      if (host_en) begin
        if (host_we && host_part == PART_SEL_WIDTH'(g)) mem[host_addr] <= host_din[PW-1:0];
        host_q <= mem[host_addr];
      end
    end

    always_ff @(posedge clk) begin
      if (rd_en) seq_q <= mem[rd_addr];
    end

    assign part_dat[g]        = 32'(host_q);
    assign rd_dat[32*g +: PW] = seq_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_q    <= '0;
      rd_seen_q <= 1'b0;
    end else if (host_en) begin
      part_q    <= host_part;
      rd_seen_q <= 1'b1;
    end
  end

  always_comb begin
    host_dout = '0;
    for (int p = 0; p < NUM_PARTS; p++)
      if (rd_seen_q && part_q == PART_SEL_WIDTH'(p)) host_dout = part_dat[p];
  end

endmodule

// File: rtl/ludh_inst_sequencer.sv
// Replays host-loaded control words to LUDHardware in run-to-length, single-step or loop mode.
// First word 2 cycles after START; locked low stalls issue while the fetched word waits in the read register.
module ludh_inst_sequencer
  import ludh_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int CTRL_WIDTH     = 72,
  parameter int PART_SEL_WIDTH = 3
) (
  input  logic                      CLK_100,
  input  logic                      RST_IN,
  input  logic                      locked,
  input  logic                      START,
  input  logic [1:0]                mode,
  input  logic [ADDR_WIDTH:0]       prog_len,
  input  logic [15:0]               loop_count,
  input  logic                      step,
  input  logic [ADDR_WIDTH-1:0]     host_addr,
  input  logic [PART_SEL_WIDTH-1:0] host_part,
  input  logic [31:0]               host_din,
  input  logic                      host_en,
  input  logic                      host_we,
  output logic [31:0]               host_dout,
  output logic [CTRL_WIDTH-1:0]     ctrl_signal,
  output logic                      ctrl_valid,
  output logic                      COMPLETED,
  output logic [31:0]               issued_count,
  output logic [1:0]                debug_state
);

  localparam int                  DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH:0]   len_q, len_clamped;
  logic [15:0]           reps_q;
  logic                  loop_q, word_vld_q, fetch_done_q, step_pend_q;
  logic                  active, issue, fetch, last_pc;
  logic [CTRL_WIDTH-1:0] rd_dat;

  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign active      = (state_q == RUN) || (state_q == STEP_WAIT);
  assign issue       = active && locked && word_vld_q;
  assign last_pc     = ({1'b0, pc_q} == len_q - (ADDR_WIDTH+1)'(1));

  ludh_inst_mem #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CTRL_WIDTH     (CTRL_WIDTH),
    .PART_SEL_WIDTH (PART_SEL_WIDTH)
  ) u_mem (
    .clk       (CLK_100),
    .rst       (RST_IN),
    .host_en   (host_en),
    .host_we   (host_we && !active),
    .host_addr (host_addr),
    .host_part (host_part),
    .host_din  (host_din),
    .host_dout (host_dout),
    .rd_en     (fetch),
    .rd_addr   (pc_q),
    .rd_dat    (rd_dat)
  );

  always_ff @(posedge CLK_100 or posedge RST_IN) begin
    if (RST_IN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    fetch       = 1'b0;
    ctrl_valid  = issue;
    ctrl_signal = issue ? rd_dat : '0;
    COMPLETED   = (state_q == DONE);
    debug_state = state_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (len_clamped == '0)      state_d = DONE;
          else if (mode == MODE_STEP) state_d = STEP_WAIT;
          else                        state_d = RUN;
        end
      end
      RUN: begin
        fetch = locked && !fetch_done_q;
        if (issue && fetch_done_q) state_d = DONE;
      end
      STEP_WAIT: begin
        fetch = locked && step_pend_q;
        if (issue && fetch_done_q) state_d = DONE;
      end
      DONE: begin
        if (!START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The memory read register doubles as the skid slot: it only reloads on fetch.
  always_ff @(posedge CLK_100 or posedge RST_IN) begin
    if (RST_IN) begin
      pc_q         <= '0;
      len_q        <= '0;
      reps_q       <= '0;
      loop_q       <= 1'b0;
      word_vld_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      step_pend_q  <= 1'b0;
      issued_count <= '0;
    end else if (state_q == IDLE && START) begin
      pc_q         <= '0;
      len_q        <= len_clamped;
      reps_q       <= (loop_count == 16'd0) ? 16'd1 : loop_count;
      loop_q       <= (mode == MODE_LOOP);
      word_vld_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      step_pend_q  <= 1'b0;
      issued_count <= '0;
    end else begin
      if (fetch) begin
        if (!last_pc) begin
          pc_q <= pc_q + ADDR_WIDTH'(1);
        end else if (loop_q && reps_q != 16'd1) begin
          pc_q   <= '0;
          reps_q <= reps_q - 16'd1;
        end else begin
          fetch_done_q <= 1'b1;
        end
      end
      if (fetch)      word_vld_q <= 1'b1;
      else if (issue) word_vld_q <= 1'b0;
      if (state_q == STEP_WAIT) begin
        if (fetch)
          step_pend_q <= 1'b0;
        else if (step && !step_pend_q && !word_vld_q && !fetch_done_q)
          step_pend_q <= 1'b1;
      end
      if (issue && issued_count != 32'hFFFF_FFFF) issued_count <= issued_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ludh_inst_sequencer.sv
// Directed bench for ludh_inst_sequencer: host port, run/loop/step modes, pause, reset.
module tb_ludh_inst_sequencer;

  localparam int AW = 12, CW = 72, PSW = 3, NLOAD = 16, DEPTH = 4096;

  logic            CLK_100 = 1'b0;
  logic            RST_IN, locked, START, step, host_en, host_we;
  logic [1:0]      mode;
  logic [AW:0]     prog_len;
  logic [15:0]     loop_count;
  logic [AW-1:0]   host_addr;
  logic [PSW-1:0]  host_part;
  logic [31:0]     host_din, host_dout, issued_count;
  logic [CW-1:0]   ctrl_signal;
  logic            ctrl_valid, COMPLETED;
  logic [1:0]      debug_state;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int addr; int part; logic [31:0] exp; } rd_vec_t;
  typedef struct { logic [1:0] md; int len; int lc; int exp_n; } run_vec_t;

  ludh_inst_sequencer dut (
    .CLK_100(CLK_100), .RST_IN(RST_IN), .locked(locked), .START(START),
    .mode(mode), .prog_len(prog_len), .loop_count(loop_count), .step(step),
    .host_addr(host_addr), .host_part(host_part), .host_din(host_din),
    .host_en(host_en), .host_we(host_we), .host_dout(host_dout),
    .ctrl_signal(ctrl_signal), .ctrl_valid(ctrl_valid), .COMPLETED(COMPLETED),
    .issued_count(issued_count), .debug_state(debug_state)
  );

  always #5 CLK_100 = ~CLK_100;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] make_word(input int i);
    logic [7:0] top;
    top = 8'hAB + 8'(i);
    return {top, 32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
  endfunction

  task automatic host_write(input int a, input int p, input logic [31:0] d);
    host_addr = AW'(a); host_part = PSW'(p); host_din = d; host_en = 1; host_we = 1;
    @(posedge CLK_100); #1;
    host_en = 0; host_we = 0;
  endtask

  task automatic host_read(input int a, input int p, output logic [31:0] d);
    host_addr = AW'(a); host_part = PSW'(p); host_en = 1; host_we = 0;
    @(posedge CLK_100); #1;
    host_en = 0;
    d = host_dout;
  endtask

  task automatic load(input int n);
    logic [CW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = make_word(i);
      host_write(i, 0, w[31:0]);
      host_write(i, 1, w[63:32]);
      host_write(i, 2, {24'hFFFFFF, w[71:64]});
    end
  endtask

  // Cycle 0 is the cycle in which START is first sampled in IDLE.
  task automatic run_case(input string nm, input logic [1:0] md, input int len, input int lc, input int exp_n);
    int got, first, last, done_c, el;
    bit order_ok, zero_ok;
    got = 0; first = -1; last = -1; done_c = -1; order_ok = 1; zero_ok = 1;
    el = (len > DEPTH) ? DEPTH : len;
    mode = md; prog_len = (AW+1)'(len); loop_count = 16'(lc); START = 1;
    for (int c = 0; c < exp_n + 20 && done_c < 0; c++) begin
      @(negedge CLK_100);
      if (ctrl_valid) begin
        if (first < 0) first = c;
        if (el > 0 && (got % el) < NLOAD && ctrl_signal !== make_word(got % el)) order_ok = 0;
        got++;
        last = c;
      end else if (ctrl_signal !== '0) zero_ok = 0;
      if (COMPLETED && done_c < 0) done_c = c;
      @(posedge CLK_100); #1;
    end
    check({nm, " valid count"}, got, exp_n);
    check({nm, " first valid cycle"}, first, (exp_n > 0) ? 2 : -1);
    check({nm, " last valid cycle"}, last, (exp_n > 0) ? 1 + exp_n : -1);
    check({nm, " completed cycle"}, done_c, (exp_n > 0) ? 2 + exp_n : 1);
    check({nm, " word order"}, order_ok, 1);
    check({nm, " idle word zero"}, zero_ok, 1);
    check({nm, " issued_count"}, issued_count, exp_n);
    check({nm, " state done"}, debug_state, 3);
    START = 0;
    @(posedge CLK_100); #1;
    check({nm, " back to idle"}, debug_state, 0);
    check({nm, " completed dropped"}, COMPLETED, 0);
  endtask

  initial begin
    rd_vec_t       rv [8];
    run_vec_t      tv [7];
    logic [31:0]   d;
    int            vcnt, got, last, st2, paused_v;
    int            vcyc [4];
    logic [CW-1:0] vword [4];
    bit            order_ok, zero_ok;

    rv[0] = '{0, 0, 32'hA000_0000};
    rv[1] = '{0, 1, 32'hB000_0000};
    rv[2] = '{0, 2, 32'h0000_00AB};
    rv[3] = '{0, 3, 32'h0000_0000};
    rv[4] = '{3, 2, 32'h0000_00AE};
    rv[5] = '{7, 1, 32'hB000_0007};
    rv[6] = '{15, 0, 32'hA000_000F};
    rv[7] = '{9, 7, 32'h0000_0000};

    tv[0] = '{2'b00, 4, 0, 4};
    tv[1] = '{2'b10, 3, 2, 6};
    tv[2] = '{2'b10, 3, 0, 3};
    tv[3] = '{2'b11, 5, 0, 5};
    tv[4] = '{2'b00, 0, 0, 0};
    tv[5] = '{2'b00, 1, 7, 1};
    tv[6] = '{2'b00, 8191, 0, 4096};

    RST_IN = 1; locked = 1; START = 0; mode = 0; prog_len = 0; loop_count = 0; step = 0;
    host_addr = 0; host_part = 0; host_din = 0; host_en = 0; host_we = 0;
    @(posedge CLK_100); #1;
    check("reset ctrl_valid", ctrl_valid, 0);
    check("reset ctrl_signal", ctrl_signal, 0);
    check("reset COMPLETED", COMPLETED, 0);
    check("reset issued_count", issued_count, 0);
    check("reset debug_state", debug_state, 0);
    check("reset host_dout", host_dout, 0);
    repeat (2) @(posedge CLK_100);
    #1 RST_IN = 0;
    @(posedge CLK_100); #1;

    load(NLOAD);
    host_write(0, 3, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      host_read(rv[i].addr, rv[i].part, d);
      check($sformatf("readback w%0d p%0d", rv[i].addr, rv[i].part), d, rv[i].exp);
    end

    for (int i = 0; i < 7; i++)
      run_case($sformatf("run%0d", i), tv[i].md, tv[i].len, tv[i].lc, tv[i].exp_n);

    // Single-step: pulses at cycles 3, 8, 13; only two words exist.
    vcnt = 0; st2 = -1;
    mode = 2'b01; prog_len = 2; loop_count = 0; START = 1;
    for (int c = 0; c < 20; c++) begin
      step = (c == 3 || c == 8 || c == 13);
      @(negedge CLK_100);
      if (c == 2) st2 = debug_state;
      if (ctrl_valid) begin
        if (vcnt < 4) begin vcyc[vcnt] = c; vword[vcnt] = ctrl_signal; end
        vcnt++;
      end
      @(posedge CLK_100); #1;
    end
    step = 0;
    check("step state wait", st2, 2);
    check("step valid count", vcnt, 2);
    check("step1 cycle", vcyc[0], 5);
    check("step2 cycle", vcyc[1], 10);
    check("step1 word", vword[0], make_word(0));
    check("step2 word", vword[1], make_word(1));
    check("step done state", debug_state, 3);
    check("step issued_count", issued_count, 2);
    START = 0;
    @(posedge CLK_100); #1;

    // Pause: locked low in cycles 7..10 (word 5 pending); host write attempted in cycle 3.
    got = 0; last = -1; paused_v = 0; order_ok = 1; zero_ok = 1;
    mode = 2'b00; prog_len = 10; START = 1;
    for (int c = 0; c < 30; c++) begin
      locked = !(c >= 7 && c <= 10);
      host_en = (c == 3); host_we = (c == 3); host_addr = 2; host_part = 0; host_din = 32'hDEAD_BEEF;
      @(negedge CLK_100);
      if (ctrl_valid) begin
        if (c >= 7 && c <= 10) paused_v++;
        if (got >= 10 || ctrl_signal !== make_word(got)) order_ok = 0;
        got++;
        last = c;
      end else if (ctrl_signal !== '0) zero_ok = 0;
      @(posedge CLK_100); #1;
    end
    host_en = 0; host_we = 0; locked = 1;
    check("pause valids while unlocked", paused_v, 0);
    check("pause total words", got, 10);
    check("pause word order", order_ok, 1);
    check("pause idle word zero", zero_ok, 1);
    check("pause last valid cycle", last, 15);
    check("pause issued_count", issued_count, 10);
    check("pause completed", COMPLETED, 1);
    START = 0;
    @(posedge CLK_100); #1;
    host_read(2, 0, d);
    check("write during run ignored", d, 32'hA000_0002);

    // Asynchronous reset in the middle of a run.
    mode = 2'b00; prog_len = 10; START = 1;
    repeat (5) begin @(posedge CLK_100); #1; end
    @(negedge CLK_100);
    check("prereset valid", ctrl_valid, 1);
    check("prereset word", ctrl_signal, make_word(3));
    #1 RST_IN = 1; START = 0;
    #1;
    check("midrun reset ctrl_valid", ctrl_valid, 0);
    check("midrun reset ctrl_signal", ctrl_signal, 0);
    check("midrun reset issued_count", issued_count, 0);
    check("midrun reset debug_state", debug_state, 0);
    check("midrun reset host_dout", host_dout, 0);
    @(posedge CLK_100); #1;
    @(posedge CLK_100); #1;
    RST_IN = 0;
    @(posedge CLK_100); #1;
    load(4);
    run_case("rerun", 2'b00, 4, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
